// File: rtl/viterbi_ctrl_if.sv
// Handshake and control bundle between the Viterbi frame sequencer and its surroundings.
// The master side drives frames in and observes the enables; the slave side is the controller.
interface viterbi_ctrl_if;
  logic       i_start;
  logic [7:0] i_frame_len;
  logic       i_sym_valid;
  logic       o_sym_ready;
  logic       o_en_bm;
  logic       o_en_acs;
  logic       o_tb_start;
  logic       o_en_tb;
  logic [7:0] o_tb_len;
  logic       i_tb_done;
  logic [7:0] o_sym_cnt;
  logic       o_busy;
  logic       o_done;
  logic       o_err;

  modport master (
    output i_start, i_frame_len, i_sym_valid, i_tb_done,
    input  o_sym_ready, o_en_bm, o_en_acs, o_tb_start, o_en_tb,
           o_tb_len, o_sym_cnt, o_busy, o_done, o_err
  );

  modport slave (
    input  i_start, i_frame_len, i_sym_valid, i_tb_done,
    output o_sym_ready, o_en_bm, o_en_acs, o_tb_start, o_en_tb,
           o_tb_len, o_sym_cnt, o_busy, o_done, o_err
  );
endinterface

// File: rtl/viterbi_ctrl.sv
// Frame sequencer for the Viterbi datapath: accepts symbols, pipelines BM/ACS enables,
// then launches and supervises traceback with a timeout.
module viterbi_ctrl #(
  parameter int TRACEBACK_DEPTH = 16,
  parameter int TB_TIMEOUT      = 64
) (
  input logic           clk,
  input logic           rst,
  viterbi_ctrl_if.slave bus
);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_RUN   = 3'd1;
  localparam logic [2:0] S_DRAIN = 3'd2;
  localparam logic [2:0] S_TB    = 3'd3;
  localparam logic [2:0] S_DONE  = 3'd4;

  localparam logic [7:0] DEPTH   = 8'(TRACEBACK_DEPTH);
  localparam logic [9:0] TIMEOUT = 10'(TB_TIMEOUT);

  logic [2:0] r_state;
  logic [7:0] r_len;
  logic [7:0] r_sym_cnt;
  logic [7:0] r_tb_len;
  logic       r_en_bm;
  logic       r_en_acs;
  logic       r_drain_cnt;
  logic [9:0] r_to_cnt;
  logic       r_err;

  logic       w_start_ok;
  logic [7:0] w_len_clip;
  logic       w_hs;
  logic       w_last_hs;
  logic       w_tb_first;
  logic       w_tb_ok;
  logic       w_tb_timeout;

  assign w_start_ok   = (r_state == S_IDLE) && bus.i_start && (bus.i_frame_len != 8'd0);
  assign w_len_clip   = (bus.i_frame_len < DEPTH) ? bus.i_frame_len : DEPTH;
  assign w_hs         = (r_state == S_RUN) && bus.i_sym_valid;
  assign w_last_hs    = w_hs && (r_sym_cnt == r_len - 8'd1);
  assign w_tb_first   = (r_state == S_TB) && (r_to_cnt == 10'd0);
  // A done in the launch cycle is stale from the previous frame, so it is not honoured.
  assign w_tb_ok      = (r_state == S_TB) && !w_tb_first && bus.i_tb_done;
  assign w_tb_timeout = (r_state == S_TB) && (r_to_cnt == TIMEOUT);

  // NOTE: sequential state uses non-blocking assignments so every register samples
  // pre-edge values; reset is synchronous and sampled only on the rising edge.
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state     <= S_IDLE;
      r_len       <= 8'd0;
      r_sym_cnt   <= 8'd0;
      r_tb_len    <= 8'd0;
      r_en_bm     <= 1'b0;
      r_en_acs    <= 1'b0;
      r_drain_cnt <= 1'b0;
      r_to_cnt    <= 10'd0;
      r_err       <= 1'b0;
    end else begin
      r_en_bm  <= w_hs;
      r_en_acs <= r_en_bm;

      case (r_state)
        S_IDLE: begin
          r_err <= 1'b0;
          if (w_start_ok) begin
            r_len     <= bus.i_frame_len;
            r_tb_len  <= w_len_clip;
            r_sym_cnt <= 8'd0;
            r_state   <= S_RUN;
          end
        end
        S_RUN: begin
          if (w_hs) begin
            r_sym_cnt <= r_sym_cnt + 8'd1;
          end
          if (w_last_hs) begin
            r_drain_cnt <= 1'b0;
            r_state     <= S_DRAIN;
          end
        end
        S_DRAIN: begin
          if (r_drain_cnt) begin
            r_to_cnt <= 10'd0;
            r_state  <= S_TB;
          end else begin
            r_drain_cnt <= 1'b1;
          end
        end
        S_TB: begin
          r_to_cnt <= r_to_cnt + 10'd1;
          if (w_tb_ok || w_tb_timeout) begin
            r_err   <= !w_tb_ok;
            r_state <= S_DONE;
          end
        end
        S_DONE: begin
          r_state <= S_IDLE;
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign bus.o_sym_ready = (r_state == S_RUN);
  assign bus.o_en_bm     = r_en_bm;
  assign bus.o_en_acs    = r_en_acs;
  assign bus.o_tb_start  = w_tb_first;
  assign bus.o_en_tb     = (r_state == S_TB);
  assign bus.o_tb_len    = r_tb_len;
  assign bus.o_sym_cnt   = r_sym_cnt;
  assign bus.o_busy      = (r_state != S_IDLE);
  assign bus.o_done      = (r_state == S_DONE);
  assign bus.o_err       = (r_state == S_DONE) && r_err;

endmodule

// File: tb/tb_viterbi_ctrl.sv
// Self-checking bench for viterbi_ctrl: a per-frame event timeline model predicts every
// output in every cycle under randomized valid patterns and traceback-done timing.
module tb_viterbi_ctrl;
  localparam int DEPTH = 16;
  localparam int TMO   = 64;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  viterbi_ctrl_if bus ();

  viterbi_ctrl #(.TRACEBACK_DEPTH(DEPTH), .TB_TIMEOUT(TMO)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  typedef struct packed {
    logic       ready;
    logic       en_bm;
    logic       en_acs;
    logic       tb_start;
    logic       en_tb;
    logic       busy;
    logic       done;
    logic       err;
    logic [7:0] tb_len;
    logic [7:0] sym_cnt;
  } outs_t;

  int checks = 0;
  int errors = 0;

  // Values the block holds across IDLE, as the model understands them.
  logic [7:0] model_cnt    = 8'd0;
  logic [7:0] model_tb_len = 8'd0;

  // Observations collected by run_frame for scenario-level checks.
  int obs_bm, obs_tb, obs_start_cyc, obs_done_cyc, obs_err, obs_hs;

  function automatic outs_t sample();
    outs_t s;
    s.ready    = bus.o_sym_ready;
    s.en_bm    = bus.o_en_bm;
    s.en_acs   = bus.o_en_acs;
    s.tb_start = bus.o_tb_start;
    s.en_tb    = bus.o_en_tb;
    s.busy     = bus.o_busy;
    s.done     = bus.o_done;
    s.err      = bus.o_err;
    s.tb_len   = bus.o_tb_len;
    s.sym_cnt  = bus.o_sym_cnt;
    return s;
  endfunction

  task automatic idle_inputs();
    bus.i_start     = 1'b0;
    bus.i_frame_len = 8'd0;
    bus.i_sym_valid = 1'b0;
    bus.i_tb_done   = 1'b0;
  endtask

  // Runs one frame from IDLE; i_start goes in cycle 0. vmode: 0 valid always, 1 valid on
  // odd cycles, 2 random. done_a/done_b are i_tb_done offsets from traceback start (-1 off).
  task automatic run_frame(input int len, input int vmode, input int done_a,
                           input int done_b, input int busy_start_cyc);
    int h_last = -1, t0 = -1, d_cyc = -1, hs = 0;
    bit errf = 1'b0, hs_prev = 1'b0, hs_prev2 = 1'b0, v, hs_now, done_in, finished = 1'b0;
    logic [7:0] clip;
    outs_t exp_o, got;
    clip = (len < DEPTH) ? 8'(len) : 8'(DEPTH);
    obs_bm = 0; obs_tb = 0; obs_start_cyc = -1; obs_done_cyc = -1; obs_err = 0; obs_hs = 0;
    for (int c = 0; c < 4000; c++) begin
      @(negedge clk);
      exp_o          = '0;
      exp_o.ready    = (c >= 1) && (h_last < 0);
      exp_o.en_bm    = hs_prev;
      exp_o.en_acs   = hs_prev2;
      exp_o.tb_start = (t0 >= 0) && (c == t0);
      exp_o.en_tb    = (t0 >= 0) && (c >= t0) && ((d_cyc < 0) || (c < d_cyc));
      exp_o.done     = (c == d_cyc);
      exp_o.err      = (c == d_cyc) && errf;
      exp_o.busy     = (c >= 1) && ((d_cyc < 0) || (c <= d_cyc));
      exp_o.tb_len   = (c >= 1) ? clip : model_tb_len;
      exp_o.sym_cnt  = (c >= 1) ? 8'(hs) : model_cnt;
      got = sample();
      checks++;
      if (got !== exp_o) begin
        errors++;
        $display("FAIL cycle_outputs len=%0d cycle=%0d got=%h expected=%h", len, c, got, exp_o);
      end
      if (got.en_bm) obs_bm++;
      if (got.en_tb) obs_tb++;
      if (got.tb_start && obs_start_cyc < 0) obs_start_cyc = c;
      if (got.done) obs_done_cyc = c;
      if (got.err) obs_err++;
      if (d_cyc >= 0 && c == d_cyc + 1) begin
        finished = 1'b1;
        break;
      end
      v = (vmode == 0) ? 1'b1 : (vmode == 1) ? (c % 2 == 1) : 1'($urandom_range(0, 1));
      done_in = (t0 >= 0) && ((done_a >= 0 && c == t0 + done_a) || (done_b >= 0 && c == t0 + done_b));
      bus.i_start     = (c == 0) || (c == busy_start_cyc);
      bus.i_frame_len = (c == 0) ? 8'(len) : 8'($urandom_range(1, 255));
      bus.i_sym_valid = v;
      bus.i_tb_done   = done_in;
      if (got.ready && v) obs_hs++;
      hs_now   = (c >= 1) && (h_last < 0) && v;
      hs_prev2 = hs_prev;
      hs_prev  = hs_now;
      if (hs_now) begin
        hs++;
        if (hs == len) begin
          h_last = c;
          t0     = c + 3;
        end
      end
      if (t0 >= 0 && d_cyc < 0 && c > t0 && done_in) begin
        d_cyc = c + 1;
        errf  = 1'b0;
      end else if (t0 >= 0 && d_cyc < 0 && c == t0 + TMO) begin
        d_cyc = c + 1;
        errf  = 1'b1;
      end
    end
    idle_inputs();
    checks++;
    if (!finished) begin
      errors++;
      $display("FAIL frame_complete len=%0d got=no_return_to_idle expected=idle_within_budget", len);
    end
    model_cnt    = 8'(len);
    model_tb_len = clip;
  endtask

  task automatic test_reset();
    idle_inputs();
    rst = 1'b0;
    repeat (2) @(negedge clk);
    checks++;
    if (sample() !== outs_t'('0)) begin
      errors++;
      $display("FAIL reset_outputs got=%h expected=0", sample());
    end
    rst = 1'b1;
    model_cnt = 8'd0;
    model_tb_len = 8'd0;
  endtask

  task automatic test_normal();
    run_frame(4, 0, 3, -1, -1);
    checks++;
    if (obs_start_cyc != 7) begin
      errors++; $display("FAIL normal_tb_start_cycle got=%0d expected=7", obs_start_cyc);
    end
    checks++;
    if (obs_done_cyc != 11 || obs_err != 0) begin
      errors++; $display("FAIL normal_done got=%0d/%0d expected=11/0", obs_done_cyc, obs_err);
    end
    checks++;
    if (bus.o_sym_cnt !== 8'd4 || bus.o_tb_len !== 8'd4 || obs_bm != 4) begin
      errors++;
      $display("FAIL normal_counts got=%0d/%0d/%0d expected=4/4/4", bus.o_sym_cnt, bus.o_tb_len, obs_bm);
    end
  endtask

  task automatic test_long_gaps();
    run_frame(20, 1, 5, -1, -1);
    checks++;
    if (obs_hs != 20 || obs_bm != 20) begin
      errors++; $display("FAIL long_pulses got=%0d/%0d expected=20/20", obs_hs, obs_bm);
    end
    checks++;
    if (bus.o_tb_len !== 8'd16) begin
      errors++; $display("FAIL long_tb_len got=%0d expected=16", bus.o_tb_len);
    end
  endtask

  task automatic test_zero_and_busy_start();
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      checks++;
      if (bus.o_busy !== 1'b0 || bus.o_sym_cnt !== model_cnt || bus.o_tb_len !== model_tb_len) begin
        errors++;
        $display("FAIL zero_len_start got=%0d/%0d/%0d expected=0/%0d/%0d",
                 bus.o_busy, bus.o_sym_cnt, bus.o_tb_len, model_cnt, model_tb_len);
      end
      bus.i_start = 1'b1;
      bus.i_frame_len = 8'd0;
    end
    idle_inputs();
    run_frame(6, 2, 4, -1, 2);
    checks++;
    if (bus.o_sym_cnt !== 8'd6) begin
      errors++; $display("FAIL busy_start_cnt got=%0d expected=6", bus.o_sym_cnt);
    end
  endtask

  task automatic test_timeout();
    run_frame(3, 0, -1, -1, -1);
    checks++;
    if (obs_tb != 65 || obs_err != 1 || obs_done_cyc != obs_start_cyc + TMO + 1) begin
      errors++;
      $display("FAIL timeout got=%0d/%0d/%0d expected=65/1/%0d",
               obs_tb, obs_err, obs_done_cyc, obs_start_cyc + TMO + 1);
    end
  endtask

  task automatic test_done_edges();
    run_frame(5, 2, 0, 7, -1);
    checks++;
    if (obs_done_cyc != obs_start_cyc + 8 || obs_err != 0) begin
      errors++;
      $display("FAIL done_in_start_cycle got=%0d/%0d expected=%0d/0",
               obs_done_cyc, obs_err, obs_start_cyc + 8);
    end
    run_frame(2, 0, TMO, -1, -1);
    checks++;
    if (obs_err != 0 || obs_tb != 65) begin
      errors++; $display("FAIL done_at_timeout got=%0d/%0d expected=0/65", obs_err, obs_tb);
    end
  endtask

  task automatic test_reset_mid();
    @(negedge clk);
    bus.i_start = 1'b1;
    bus.i_frame_len = 8'd8;
    bus.i_sym_valid = 1'b1;
    @(negedge clk);
    bus.i_start = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    checks++;
    if (sample() !== outs_t'('0)) begin
      errors++; $display("FAIL reset_mid_outputs got=%h expected=0", sample());
    end
    rst = 1'b1;
    idle_inputs();
    repeat (3) begin
      @(negedge clk);
      checks++;
      if (bus.o_done !== 1'b0 || bus.o_err !== 1'b0 || bus.o_busy !== 1'b0) begin
        errors++;
        $display("FAIL reset_mid_quiet got=%0d/%0d/%0d expected=0/0/0",
                 bus.o_done, bus.o_err, bus.o_busy);
      end
    end
    model_cnt = 8'd0;
    model_tb_len = 8'd0;
    run_frame(2, 0, 2, -1, -1);
  endtask

  task automatic test_random();
    for (int i = 0; i < 6; i++) begin
      int len, da;
      len = $urandom_range(1, 40);
      da  = ($urandom_range(0, 3) == 0) ? -1 : int'($urandom_range(1, 70));
      run_frame(len, 2, da, -1, int'($urandom_range(1, 4)));
    end
  endtask

  initial begin
    idle_inputs();
    test_reset();
    test_normal();
    test_long_gaps();
    test_zero_and_busy_start();
    test_timeout();
    test_done_edges();
    test_reset_mid();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
